// File: rtl/negate_rr_arbiter.sv
// -----------------------------------------------------------------------------
// negate_rr_arbiter
//
// Shares one two's-complement negate / absolute-value datapath between R
// requesters. A round-robin arbiter picks one valid requester per cycle. Its
// operand is transformed and registered into a single-entry result slot. The
// slot is tagged with the requester id and an overflow flag.
//
// Ports:
//   clk        in   clock, rising edge active
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [R]    requester i presents an operand
//   req_data   in   [R*N]  operand of requester i in bits [i*N +: N]
//   req_abs    in   [R]    1 = absolute value, 0 = negate
//   req_ready  out  [R]    requester i's operand is accepted this cycle
//   res_valid  out         result slot holds a valid result
//   res_ready  in          consumer takes the result this cycle
//   res_data   out  [N]    result value
//   res_id     out  [IDW]  index of the requester that produced the result
//   res_ovf    out         operand was 100..0 and negation was applied
// -----------------------------------------------------------------------------
module negate_rr_arbiter #(
    parameter int N   = 4,
    parameter int R   = 4,
    parameter int IDW = $clog2(R)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [R-1:0]     req_valid,
    input  logic [R*N-1:0]   req_data,
    input  logic [R-1:0]     req_abs,
    output logic [R-1:0]     req_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_data,
    output logic [IDW-1:0]   res_id,
    output logic             res_ovf
);

    localparam logic [N-1:0]   MIN_VAL = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]   ONE_VAL = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0] PTR_RST = IDW'(R - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    res_data_q, res_data_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic            res_ovf_q, res_ovf_d;
    logic [IDW-1:0]  ptr_q, ptr_d;

    logic [N-1:0]    op_arr [R];
    logic [R-1:0]    grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_found;
    logic            slot_free;
    logic            transfer;

    logic [N-1:0]    sel_op;
    logic            sel_abs;
    logic            apply_neg;
    logic [N-1:0]    neg_val;
    logic [N-1:0]    result_val;
    logic            result_ovf;

    // A new result can be loaded while the current one drains.
    assign slot_free = (state_q == EMPTY) || res_ready;
    assign transfer  = grant_found && slot_free;

    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_req
            assign op_arr[gi]    = req_data[gi*N +: N];
            assign req_ready[gi] = grant[gi] && slot_free;
        end
    endgenerate

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int             idx_int;
        logic [IDW-1:0] idx;
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        idx_int     = 0;
        idx         = '0;
        for (int k = 1; k <= R; k++) begin
            idx_int = (int'(ptr_q) + k) % R;
            idx     = idx_int[IDW-1:0];
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

    // Shared datapath: negate unless abs was asked for and the operand is
    // already non-negative. Negating the most negative value wraps onto itself.
    always_comb begin
        sel_op     = op_arr[grant_id];
        sel_abs    = req_abs[grant_id];
        apply_neg  = !sel_abs || sel_op[N-1];
        neg_val    = ~sel_op + ONE_VAL;
        result_val = apply_neg ? neg_val : sel_op;
        result_ovf = apply_neg && (sel_op == MIN_VAL);
    end

    // Slot control and payload next-state.
    always_comb begin
        state_d    = state_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        res_ovf_d  = res_ovf_q;
        ptr_d      = ptr_q;

        case (state_q)
            EMPTY: begin
                if (transfer) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (transfer) begin
                    state_d = FULL;
                end else if (res_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Payload is only written on a transfer; a plain drain leaves the old
        // values in place and stalls leave everything untouched.
        if (transfer) begin
            res_data_d = result_val;
            res_id_d   = grant_id;
            res_ovf_d  = result_ovf;
            ptr_d      = grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            res_data_q <= '0;
            res_id_q   <= '0;
            res_ovf_q  <= 1'b0;
            ptr_q      <= PTR_RST;
        end else begin
            state_q    <= state_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
            res_ovf_q  <= res_ovf_d;
            ptr_q      <= ptr_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_negate_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_negate_rr_arbiter
//
// Self-checking bench for negate_rr_arbiter (N=4, R=4). Directed scenarios
// are followed by randomized traffic. A reference model tracks the slot and
// the round-robin pointer using plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_negate_rr_arbiter;

    localparam int N   = 4;
    localparam int R   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [R-1:0]     req_valid;
    logic [R*N-1:0]   req_data;
    logic [R-1:0]     req_abs;
    logic [R-1:0]     req_ready;
    logic             res_valid;
    logic             res_ready;
    logic [N-1:0]     res_data;
    logic [IDW-1:0]   res_id;
    logic             res_ovf;

    negate_rr_arbiter #(.N(N), .R(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_abs   (req_abs),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_valid;
    int m_data, m_id, m_ovf, m_ptr;
    int ops [R];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Result computed on the signed interpretation of the operand.
    function automatic int ref_value(input int x, input bit ab);
        int sv;
        sv = (x >= 2**(N-1)) ? x - 2**N : x;
        if (!ab || sv < 0) sv = -sv;
        return ((sv % (2**N)) + 2**N) % (2**N);
    endfunction

    function automatic int ref_ovf(input int x, input bit ab);
        bit negated;
        negated = !ab || (x >= 2**(N-1));
        return (negated && x == 2**(N-1)) ? 1 : 0;
    endfunction

    // Asserted at a negedge; checks the asynchronous clear before any edge.
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_abs   = '0;
        res_ready = 1'b0;
        m_valid   = 0;
        m_data    = 0;
        m_id      = 0;
        m_ovf     = 0;
        m_ptr     = R - 1;
        #1;
        chk("rst_valid", res_valid, 0);
        chk("rst_data",  res_data,  0);
        chk("rst_id",    res_id,    0);
        chk("rst_ovf",   res_ovf,   0);
        chk("rst_ready", req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive at negedge, check ready, update model at posedge,
    // check slot after the edge. Returns the granted requester or -1.
    task automatic cycle(input logic [R-1:0] v, input logic [R-1:0] ab,
                         input logic rr, output int granted);
        int g;
        bit free;
        int idx;
        logic [R-1:0] exp_ready;
        logic [N-1:0] opv;
        req_valid = v;
        req_abs   = ab;
        res_ready = rr;
        for (int i = 0; i < R; i++) begin
            opv = ops[i][N-1:0];
            req_data[i*N +: N] = opv;
        end
        #1;
        free = !m_valid || rr;
        g = -1;
        for (int k = 1; k <= R; k++) begin
            idx = (m_ptr + k) % R;
            if (g < 0 && v[idx]) g = idx;
        end
        exp_ready = (free && g >= 0) ? (R'(1) << g) : '0;
        chk("req_ready", req_ready, exp_ready);
        @(posedge clk);
        if (free && g >= 0) begin
            m_valid = 1;
            m_data  = ref_value(ops[g], ab[g]);
            m_ovf   = ref_ovf(ops[g], ab[g]);
            m_id    = g;
            m_ptr   = g;
            granted = g;
        end else begin
            if (m_valid && rr) m_valid = 0;
            granted = -1;
        end
        #1;
        chk("res_valid", res_valid, m_valid);
        if (m_valid) begin
            chk("res_data", res_data, m_data);
            chk("res_id",   res_id,   m_id);
            chk("res_ovf",  res_ovf,  m_ovf);
        end
        @(negedge clk);
    endtask

    initial begin
        int g;
        logic [R-1:0] pend_v, pend_ab;

        for (int i = 0; i < R; i++) ops[i] = 0;
        req_data = '0;
        do_reset();

        // Basic ops
        ops[1] = 3;
        cycle(4'b0010, 4'b0000, 1'b1, g);
        $display("basic neg 0011: id=%0d data=%h ovf=%0d", res_id, res_data, res_ovf);
        chk("basic_neg_data", res_data, 4'hD);
        chk("basic_neg_id",   res_id,   1);
        chk("basic_neg_ovf",  res_ovf,  0);
        ops[2] = 10;
        cycle(4'b0100, 4'b0100, 1'b1, g);
        chk("abs_1010", res_data, 4'h6);
        ops[2] = 5;
        cycle(4'b0100, 4'b0100, 1'b1, g);
        chk("abs_0101", res_data, 4'h5);

        // Overflow and zero
        ops[0] = 8;
        cycle(4'b0001, 4'b0000, 1'b1, g);
        chk("neg_min_data", res_data, 4'h8);
        chk("neg_min_ovf",  res_ovf,  1);
        cycle(4'b0001, 4'b0001, 1'b1, g);
        chk("abs_min_data", res_data, 4'h8);
        chk("abs_min_ovf",  res_ovf,  1);
        ops[0] = 0;
        cycle(4'b0001, 4'b0000, 1'b1, g);
        chk("neg_zero_data", res_data, 0);
        chk("neg_zero_ovf",  res_ovf,  0);

        // Round-robin from reset: 0,1,2,3,0,1
        do_reset();
        for (int i = 0; i < R; i++) ops[i] = $urandom_range(0, 15);
        for (int k = 0; k < 6; k++) begin
            cycle(4'b1111, 4'($urandom_range(0, 15)), 1'b1, g);
            $display("rr cycle %0d: granted %0d", k, g);
            chk("rr_order", g, k % R);
        end

        // Backpressure: last granted was 1, so 2 follows after the stall
        for (int k = 0; k < 3; k++) begin
            cycle(4'b1111, 4'b0000, 1'b0, g);
            chk("bp_no_grant", g, -1);
            chk("bp_id_hold",  res_id, 1);
        end
        cycle(4'b1111, 4'b0000, 1'b1, g);
        chk("bp_resume", g, 2);

        // Priority retention across idle cycles
        do_reset();
        cycle(4'b1000, 4'b0000, 1'b1, g);
        chk("pri_r3", g, 3);
        cycle(4'b0000, 4'b0000, 1'b1, g);
        cycle(4'b0000, 4'b0000, 1'b1, g);
        cycle(4'b1001, 4'b0000, 1'b1, g);
        chk("pri_r0", g, 0);

        // Reset mid-stream with a stalled result
        cycle(4'b0100, 4'b0000, 1'b1, g);
        cycle(4'b0000, 4'b0000, 1'b0, g);
        chk("pre_rst_valid", res_valid, 1);
        do_reset();
        cycle(4'b0101, 4'b0000, 1'b1, g);
        chk("post_rst_grant", g, 0);

        // Random traffic honouring the hold-until-ready rule
        pend_v  = '0;
        pend_ab = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < R; i++) begin
                if (!pend_v[i] && ($urandom_range(0, 1) == 1)) begin
                    pend_v[i]  = 1'b1;
                    pend_ab[i] = 1'($urandom_range(0, 1));
                    ops[i]     = $urandom_range(0, 15);
                end
            end
            cycle(pend_v, pend_ab, ($urandom_range(0, 3) != 0), g);
            if (g >= 0) pend_v[g] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/negate_rr_arbiter.md
Name: negate_rr_arbiter

Overview:
- Shares one two's-complement negation/absolute-value datapath between R requesters.
- Arbitrates with a round-robin scheme and uses valid/ready handshakes on both sides.
- Registers one result per cycle into a single-entry output slot, tagged with the requester id and an overflow flag.
- Sits between several arithmetic producers (e.g. subtractor front-ends, sign-magnitude converters) and a downstream consumer.

Parameters:
- N, 4, data width in bits (N >= 2).
- R, 4, number of requesters (R >= 2).
- IDW, $clog2(R), width of the requester id (derived; not to be overridden).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  input  R  bit i: requester i presents an operand.
- req_data  input  R*N  operand of requester i in bits [i*N +: N].
- req_abs  input  R  bit i: 1 = absolute value, 0 = negate.
- req_ready  output  R  bit i: requester i's operand is accepted this cycle.
- res_valid  output  1  result slot holds a valid result.
- res_ready  input  1  consumer accepts the result this cycle.
- res_data  output  N  result value.
- res_id  output  IDW  index of the requester that produced the result.
- res_ovf  output  1  the operand was 2^(N-1) (100..0) and negation was applied.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - res_valid=0, res_data=0, res_id=0, res_ovf=0.
  - Round-robin pointer ptr=R-1, so requester 0 has highest priority after reset.
- slot_free = !res_valid || res_ready. A result may be loaded in the same cycle the previous one drains.
- Grant (combinational):
  - Search order ptr+1, ptr+2, ..., ptr+R, all mod R.
  - The first i with req_valid[i]=1 is granted (one-hot).
  - req_ready[i] = grant[i] && slot_free.
  - req_ready is never high for a requester whose valid is low.
  - At most one req_ready bit is high per cycle.
- Transfer: req_valid[g] && req_ready[g]. On the next rising edge:
  - res_valid=1, res_id=g, ptr=g.
  - res_data = req_abs[g] ? (x[N-1] ? (~x+1) mod 2^N : x) : (~x+1) mod 2^N, where x is the operand of g.
  - res_ovf = (x == 2^(N-1)) && (negation applied). Abs of a non-negative operand never sets ovf.
  - Latency is one cycle from accepted operand to res_valid.
  - Throughput is one result per cycle when res_ready is held high.
- Drain without refill (res_valid && res_ready, no transfer): res_valid goes to 0 next edge. res_data, res_id and res_ovf keep their last values and are don't-care to the consumer.
- Backpressure (res_valid && !res_ready):
  - res_data, res_id and res_ovf hold stable.
  - All req_ready bits are 0 and ptr holds.
- ptr changes only on a transfer. Idle cycles and stalled cycles do not rotate priority.
- Width rules:
  - All negation is mod 2^N. No carry out is kept.
  - Negate of 0 is 0 with ovf=0.
  - Negate of 100..0 is 100..0 with ovf=1.
- Requester-side rule: a requester must hold req_valid, req_data and req_abs stable until it sees req_ready. This is not checked by the block.
- Reset mid-operation: a pending result is discarded (res_valid drops immediately and asynchronously) and ptr returns to R-1. No result is emitted for an operand that was not yet accepted.
- Fairness: with all requesters continuously valid and res_ready=1, grants cycle 0,1,...,R-1,0,... Any continuously valid requester is granted within R transfers.
- Two-state control (EMPTY / FULL, reflected by res_valid):
  - EMPTY -> FULL on a transfer.
  - FULL -> FULL on drain+refill or on stall.
  - FULL -> EMPTY on drain with no transfer.

Test Plan:
- Basic ops, N=4: requester 1 negates 0011 -> res_data=1101, res_id=1, ovf=0, one cycle after req_ready[1]. Then requester 2 abs of 1010 -> 0110. Then abs of 0101 -> 0101.
- Overflow and zero: negate 1000 -> res_data=1000, ovf=1. Abs 1000 -> 1000, ovf=1. Negate 0000 -> 0000, ovf=0.
- Round-robin: all four req_valid held high, res_ready=1 -> res_id sequence 0,1,2,3,0,1 on consecutive cycles, with exactly one req_ready bit high per cycle.
- Backpressure: res_ready=0 for 3 cycles while a result is valid -> outputs stable, req_ready all 0, ptr unchanged. Raise res_ready -> the next requester in order is accepted in that same cycle.
- Priority retention: only requester 3 valid, then requesters 0 and 3 valid together -> requester 0 is granted next (ptr=3). Idle cycles in between leave the order unchanged.
- Reset mid-stream: assert rst_n=0 while res_valid=1 and res_ready=0 -> res_valid=0 immediately. After release with requesters 2 and 0 valid, requester 0 is granted first.
